// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: round-robin front end that shares one fixed-latency,
// stallable pipeline among NREQ requesters. Each beat's valid bit and
// requester ID travel through a shadow shift register that moves in lockstep
// with the pipeline. The ID is reunited with the result at the tail.
module pipeline_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [XLEN-1:0]      pipe_data_in,
    output logic                 pipe_stall,
    input  logic [XLEN-1:0]      pipe_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic [XLEN-1:0]      out_data,
    output logic [CW-1:0]        inflight
);

    localparam int unsigned NR = NREQ;

    logic [DEPTH-1:0]          vld;
    logic [DEPTH-1:0][IDW-1:0] id;
    logic [IDW-1:0]            last;
    logic                      en;
    logic                      pop;
    logic                      gnt_any;
    logic [IDW-1:0]            gnt_id;

    // Only a valid beat at the tail that downstream refuses can stall.
    assign pipe_stall = vld[DEPTH-1] && !out_ready;
    assign en         = !pipe_stall;
    assign pop        = vld[DEPTH-1] && out_ready;

    assign out_valid  = vld[DEPTH-1];
    assign out_id     = id[DEPTH-1];
    assign out_data   = pipe_data_out;

    // Cyclic priority search starting one past the most recent grantee
    always_comb begin
        int unsigned cand;
        cand      = 0;
        gnt_any   = 1'b0;
        gnt_id    = '0;
        req_ready = '0;
        if (resetn && en) begin
            for (int unsigned k = 1; k <= NR; k++) begin
                cand = (32'(last) + k) % NR;
                if (!gnt_any && req_valid[IDW'(cand)]) begin
                    gnt_any               = 1'b1;
                    gnt_id                = IDW'(cand);
                    req_ready[IDW'(cand)] = 1'b1;
                end
            end
        end
    end

    // Steer the grantee's data into the pipeline; bubbles carry zero
    always_comb begin
        pipe_data_in = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                pipe_data_in = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Shadow valid/ID shift register and round-robin pointer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld  <= '0;
            id   <= '0;
            last <= IDW'(NREQ - 1);
        end else if (en) begin
            vld <= {vld[DEPTH-2:0], gnt_any};
            id  <= {id[DEPTH-2:0], gnt_id};
            if (gnt_any) begin
                last <= gnt_id;
            end
        end
    end

    // Occupancy: +1 on grant, -1 on output handshake, both together cancel
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            inflight <= '0;
        end else if (en) begin
            if (gnt_any && !pop) begin
                inflight <= inflight + CW'(1);
            end else if (!gnt_any && pop) begin
                inflight <= inflight - CW'(1);
            end
        end
    end

endmodule
